// File: rtl/fetch_unit.sv
// Instruction fetch front end: word-aligned PC generation, single-outstanding
// req/ack memory fetch, and a {pc, instruction} FIFO toward decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   drain_pc;
  logic [31:0]   fifo_pc  [DEPTH];
  logic [31:0]   fifo_ins [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic          redir_en;
  logic          push;
  logic          pop;
  logic [31:0]   new_pc;
  logic          unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Request depends only on registered state, so it cannot drop mid-transaction:
  // count only grows on the ack that ends a request.
  always_comb begin
    imem_req = 1'b0;
    case (state)
      FETCH:   imem_req = (count < FULL);
      DRAIN:   imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  always_comb begin
    imem_addr   = (state == DRAIN) ? drain_pc : fetch_pc;
    new_pc      = {redirect_pc[31:2], 2'b00};
    redir_en    = redirect && (state != IDLE);
    push        = (state == FETCH) && imem_req && imem_ack && !redir_en;
    instr_valid = (count != '0);
    pop         = instr_valid && instr_ready && !redir_en;
    instruction = instr_valid ? fifo_ins[rd_ptr] : '0;
    instr_pc    = instr_valid ? fifo_pc[rd_ptr]  : '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      drain_pc <= RESET_PC;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (redirect) begin
            fetch_pc <= new_pc;
            // An unacknowledged request must still be completed with its old address.
            if (imem_req && !imem_ack) begin
              state    <= DRAIN;
              drain_pc <= fetch_pc;
            end
          end else if (imem_req && imem_ack) begin
            fetch_pc <= fetch_pc + 32'd4;
          end
        end
        DRAIN: begin
          if (redirect) fetch_pc <= new_pc;
          if (imem_ack) state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redir_en) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]  <= fetch_pc;
      fifo_ins[wr_ptr] <= imem_rdata;
    end
  end

endmodule
